// File: rtl/snd_cmd_pkg.sv
// Shared state type and parameter defaults for the sound-command mailbox.
package snd_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ASSERT    = 2'd1,
    WAIT_READ = 2'd2
  } snd_mbox_state_t;

  localparam int SND_IRQ_TIMEOUT_DEF = 4096;
  localparam int SND_FIFO_DEPTH_DEF  = 4;

endpackage

// File: rtl/snd_cmd_fifo.sv
// Command FIFO for snd_cmd_mailbox, built only when SND_CMD_FIFO_EN is defined.
// data shows the head entry, or the last stored byte once the FIFO has drained.
`ifdef SND_CMD_FIFO_EN
module snd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] data,
  output logic [3:0]   level,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    count;
  logic [W-1:0]  last_q;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == 4'd0);
  assign full    = (count == 4'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        last_q <= wdata;
      end
      count <= count + 4'(push_ok) - 4'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  assign data  = empty ? last_q : mem[rd_ptr];
  assign level = count;

endmodule
`endif

// File: rtl/snd_cmd_mailbox.sv
// Main-CPU to sound-CPU command mailbox with interrupt sequencing and timeout.
// SND_CMD_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of the single board latch.
module snd_cmd_mailbox
  import snd_cmd_pkg::*;
#(
  parameter int IRQ_TIMEOUT = SND_IRQ_TIMEOUT_DEF,
  parameter int FIFO_DEPTH  = SND_FIFO_DEPTH_DEF
) (
  input  logic       clk_49m,
  input  logic       reset,
  input  logic       pause,
  input  logic [7:0] cmd_data,
  input  logic       cmd_wr,
  input  logic       snd_rd,
  input  logic       snd_irq_ack,
  output logic [7:0] snd_data,
  output logic       snd_irq_n,
  output logic       cmd_pending,
  output logic       overrun,
  output logic [3:0] fifo_level
);

  localparam logic [15:0] TMO_LAST = 16'(IRQ_TIMEOUT - 1);

  logic            cmd_wr_q;
  logic            snd_rd_q;
  logic            ack_q;
  logic            push;
  logic            pop;
  logic            ack;
  logic            full;
  snd_mbox_state_t state;
  snd_mbox_state_t state_nxt;
  logic [15:0]     tmo_cnt;
  logic            tmo_hit;

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      cmd_wr_q <= 1'b0;
      snd_rd_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cmd_wr_q <= cmd_wr;
      snd_rd_q <= snd_rd;
      ack_q    <= snd_irq_ack;
    end
  end

  assign push = cmd_wr & ~cmd_wr_q;
  assign pop  = ~snd_rd & snd_rd_q & cmd_pending;
  assign ack  = snd_irq_ack & ~ack_q;

`ifdef SND_CMD_FIFO_EN
  logic fifo_empty;

  snd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk   (clk_49m),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_data),
    .data  (snd_data),
    .level (fifo_level),
    .full  (full),
    .empty (fifo_empty)
  );

  assign cmd_pending = ~fifo_empty;
`else
  // Single board latch: FIFO_DEPTH does not size it.
  localparam int LATCH_DEPTH = 1 + 0 * FIFO_DEPTH;

  logic [7:0] latch_q;
  logic       full_q;

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      latch_q <= 8'h00;
      full_q  <= 1'b0;
    end else if (push) begin
      latch_q <= cmd_data;
      full_q  <= 1'b1;
    end else if (pop) begin
      full_q  <= 1'b0;
    end
  end

  assign snd_data    = latch_q;
  assign fifo_level  = {3'b000, full_q};
  assign full        = (fifo_level == 4'(LATCH_DEPTH));
  assign cmd_pending = full_q;
`endif

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) overrun <= 1'b0;
    else if (push & full & ~pop) overrun <= 1'b1;
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end

  assign tmo_hit = (state == ASSERT) && !pause && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (cmd_pending && !pause) state_nxt = ASSERT;
      // Polling drivers read without acknowledging, so a pop also ends ASSERT.
      ASSERT: begin
        if (pop)          state_nxt = IDLE;
        else if (ack)     state_nxt = WAIT_READ;
        else if (tmo_hit) state_nxt = IDLE;
      end
      WAIT_READ: if (pop) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) tmo_cnt <= '0;
    else if (state == IDLE && state_nxt == ASSERT) tmo_cnt <= '0;
    else if (state == ASSERT && !pause) tmo_cnt <= tmo_cnt + 16'd1;
  end

  always_comb begin
    snd_irq_n = (state != ASSERT);
  end

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Scoreboard bench for snd_cmd_mailbox: a queue-based reference model predicts every
// cycle's outputs; directed test-plan scenarios run first, then randomized traffic.
module tb_snd_cmd_mailbox;

  localparam int TO    = 16;
  localparam int DEPTH = 4;
`ifdef SND_CMD_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif
  localparam int PH_IDLE = 0;
  localparam int PH_LOW  = 1;
  localparam int PH_WAIT = 2;

  logic       clk_49m = 1'b0;
  logic       reset;
  logic       pause;
  logic [7:0] cmd_data;
  logic       cmd_wr;
  logic       snd_rd;
  logic       snd_irq_ack;
  logic [7:0] snd_data;
  logic       snd_irq_n;
  logic       cmd_pending;
  logic       overrun;
  logic [3:0] fifo_level;

  snd_cmd_mailbox #(
    .IRQ_TIMEOUT (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_49m     (clk_49m),
    .reset       (reset),
    .pause       (pause),
    .cmd_data    (cmd_data),
    .cmd_wr      (cmd_wr),
    .snd_rd      (snd_rd),
    .snd_irq_ack (snd_irq_ack),
    .snd_data    (snd_data),
    .snd_irq_n   (snd_irq_n),
    .cmd_pending (cmd_pending),
    .overrun     (overrun),
    .fifo_level  (fifo_level)
  );

  always #5 clk_49m = ~clk_49m;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: entries held as a plain byte queue.
  typedef struct {
    logic [7:0] d;
    bit         irq_n;
    bit         pend;
    bit         ovr;
    int         lvl;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  bit         m_ovr;
  logic [7:0] m_last;
  int         m_phase;
  int         m_low;
  bit         m_wr_p, m_rd_p, m_ack_p;

  task automatic m_reset();
    m_q.delete();
    m_ovr   = 0;
    m_last  = 8'h00;
    m_phase = PH_IDLE;
    m_low   = 0;
    m_wr_p  = 0;
    m_rd_p  = 0;
    m_ack_p = 0;
  endtask

  task automatic m_step();
    bit wr_rise, rd_fall, ack_rise, pend, took;
    wr_rise  = cmd_wr && !m_wr_p;
    rd_fall  = !snd_rd && m_rd_p;
    ack_rise = snd_irq_ack && !m_ack_p;
    pend     = (m_q.size() != 0);
    took     = rd_fall && pend;
    case (m_phase)
      PH_IDLE: if (pend && !pause) begin m_phase = PH_LOW; m_low = 0; end
      PH_LOW: begin
        if (took) m_phase = PH_IDLE;
        else if (ack_rise) m_phase = PH_WAIT;
        else if (!pause) begin
          m_low++;
          if (m_low == TO) m_phase = PH_IDLE;
        end
      end
      default: if (took) m_phase = PH_IDLE;
    endcase
`ifdef SND_CMD_FIFO_EN
    if (took) void'(m_q.pop_front());
    if (wr_rise) begin
      if (m_q.size() < CAP) begin m_q.push_back(cmd_data); m_last = cmd_data; end
      else m_ovr = 1;
    end
`else
    if (wr_rise) begin
      if (pend && !took) m_ovr = 1;
      m_q.delete();
      m_q.push_back(cmd_data);
      m_last = cmd_data;
    end else if (took) begin
      m_q.delete();
    end
`endif
    m_wr_p  = cmd_wr;
    m_rd_p  = snd_rd;
    m_ack_p = snd_irq_ack;
  endtask

  always @(posedge clk_49m) begin
    exp_t e;
    if (reset) m_reset();
    else m_step();
    e.d     = (m_q.size() != 0) ? m_q[0] : m_last;
    e.irq_n = (m_phase != PH_LOW);
    e.pend  = (m_q.size() != 0);
    e.ovr   = m_ovr;
    e.lvl   = m_q.size();
    exp_q.push_back(e);
  end

  always @(posedge clk_49m) begin
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: no expected entry at %0t", $time);
    end else begin
      exp_t e;
      e = exp_q.pop_front();
      chk("snd_data", int'(snd_data), int'(e.d));
      chk("snd_irq_n", int'(snd_irq_n), int'(e.irq_n));
      chk("cmd_pending", int'(cmd_pending), int'(e.pend));
      chk("overrun", int'(overrun), int'(e.ovr));
      chk("fifo_level", int'(fifo_level), e.lvl);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_49m);
  endtask

  task automatic do_write(input logic [7:0] d, input int hold);
    @(negedge clk_49m);
    cmd_data = d;
    cmd_wr   = 1'b1;
    tick(hold);
    cmd_wr   = 1'b0;
  endtask

  task automatic do_ack(input int hold);
    @(negedge clk_49m);
    snd_irq_ack = 1'b1;
    tick(hold);
    snd_irq_ack = 1'b0;
  endtask

  task automatic do_read(input int hold);
    @(negedge clk_49m);
    snd_rd = 1'b1;
    tick(hold);
    snd_rd = 1'b0;
    tick(1);
  endtask

  initial begin
    bit irq_hist[60];
    int first_low, low_run, high_run, relow;

    reset = 1'b1; pause = 1'b0; cmd_wr = 1'b0; snd_rd = 1'b0;
    snd_irq_ack = 1'b0; cmd_data = 8'h00;
    m_reset();
    #2;
    chk("reset_snd_data", int'(snd_data), 0);
    chk("reset_irq_n", int'(snd_irq_n), 1);
    chk("reset_pending", int'(cmd_pending), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_level", int'(fifo_level), 0);
    @(negedge clk_49m);
    reset = 1'b0;
    tick(2);

    // Basic transfer
    do_write(8'h5A, 10);
    chk("basic_irq_low", int'(snd_irq_n), 0);
    chk("basic_pending", int'(cmd_pending), 1);
    do_ack(2);
    chk("basic_irq_after_ack", int'(snd_irq_n), 1);
    do_read(2);
    chk("basic_pending_after_read", int'(cmd_pending), 0);
    chk("basic_data_after_read", int'(snd_data), 8'h5A);
    tick(2);

    // Timeout: never acknowledge
    @(negedge clk_49m);
    cmd_data = 8'h11;
    cmd_wr   = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk_49m);
      #1;
      irq_hist[i] = snd_irq_n;
      @(negedge clk_49m);
      if (i == 2) cmd_wr = 1'b0;
    end
    first_low = 60;
    for (int i = 59; i >= 0; i--) if (!irq_hist[i]) first_low = i;
    low_run = 0; high_run = 0; relow = 0;
    begin
      int k;
      k = first_low;
      while (k < 60 && !irq_hist[k]) begin low_run++; k++; end
      while (k < 60 && irq_hist[k]) begin high_run++; k++; end
      if (k < 60) relow = 1;
    end
    chk("timeout_low_cycles", low_run, TO);
    chk("timeout_high_gap", high_run, 1);
    chk("timeout_reasserts", relow, 1);
    chk("timeout_pending", int'(cmd_pending), 1);
    do_read(2);
    tick(3);

    // Pause holds off the interrupt
    @(negedge clk_49m);
    pause = 1'b1;
    do_write(8'h33, 2);
    tick(5);
    chk("pause_irq_held", int'(snd_irq_n), 1);
    chk("pause_pending", int'(cmd_pending), 1);
    @(negedge clk_49m);
    pause = 1'b0;
    @(posedge clk_49m);
    #1;
    chk("pause_release_irq", int'(snd_irq_n), 0);
    do_ack(2);
    do_read(2);
    tick(3);

    // Simultaneous push and pop at level 1
    do_write(8'hA1, 2);
    tick(1);
    @(negedge clk_49m);
    snd_rd = 1'b1;
    tick(2);
    cmd_data = 8'hB2;
    cmd_wr   = 1'b1;
    snd_rd   = 1'b0;
    tick(1);
    chk("simul_level", int'(fifo_level), 1);
    chk("simul_overrun", int'(overrun), 0);
    chk("simul_head", int'(snd_data), 8'hB2);
    cmd_wr = 1'b0;
    tick(2);
    do_read(2);
    tick(3);

    // Overrun
    do_write(8'h01, 2);
    do_write(8'h02, 2);
    tick(1);
`ifdef SND_CMD_FIFO_EN
    chk("ovr_head", int'(snd_data), 8'h01);
    chk("ovr_not_yet", int'(overrun), 0);
    do_write(8'h03, 2);
    do_write(8'h04, 2);
    tick(1);
    chk("ovr_full_level", int'(fifo_level), DEPTH);
    chk("ovr_at_depth", int'(overrun), 0);
    do_write(8'h05, 2);
    tick(1);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_level_kept", int'(fifo_level), DEPTH);
    chk("ovr_head_kept", int'(snd_data), 8'h01);
`else
    chk("ovr_latch_data", int'(snd_data), 8'h02);
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_level", int'(fifo_level), 1);
`endif
    repeat (CAP) do_read(2);
    chk("ovr_drained", int'(fifo_level), 0);
    tick(3);

    // Reset while the interrupt is asserted
    do_write(8'h21, 2);
    do_write(8'h22, 2);
    tick(3);
    chk("rst_mid_irq_low", int'(snd_irq_n), 0);
    @(posedge clk_49m);
    #3;
    reset = 1'b1;
    m_reset();
    #1;
    chk("rst_async_irq", int'(snd_irq_n), 1);
    chk("rst_async_level", int'(fifo_level), 0);
    chk("rst_async_overrun", int'(overrun), 0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("rst_no_irq_after", int'(snd_irq_n), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_49m);
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        reset = 1'b1;
        m_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          cmd_wr = ~cmd_wr;
          if (cmd_wr) cmd_data = 8'($urandom);
        end
        if ($urandom_range(0, 4) == 0) snd_rd = ~snd_rd;
        if ($urandom_range(0, 5) == 0) snd_irq_ack = ~snd_irq_ack;
        if ($urandom_range(0, 19) == 0) pause = ~pause;
      end
    end
    @(negedge clk_49m);
    reset = 1'b0; pause = 1'b0; cmd_wr = 1'b0; snd_rd = 1'b0; snd_irq_ack = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/snd_cmd_mailbox.md
# snd_cmd_mailbox

Command mailbox and interrupt sequencer between the main CPU board and the sound board. Captures each byte the main CPU writes to the sound-command port and holds it for the sound CPU. Raises the sound CPU's interrupt, waits for acknowledge and read, then releases the entry. Sits on the `sound_cmd` / `sound_cmd_wr` path between `BluePrint_CPU` and `BluePrint_SND`.

## Interface
Parameters:
- `IRQ_TIMEOUT`, default 4096: clk_49m cycles that `snd_irq_n` may stay low without acknowledge before it is withdrawn. Range 2..65535.
- `FIFO_DEPTH`, default 4: entries when `SND_CMD_FIFO_EN` is defined. Power of 2, 2..8.

Ports:
- `clk_49m` in 1: sole clock.
- `reset` in 1: asynchronous, active-high.
- `pause` in 1: freezes interrupt scheduling.
- `cmd_data` in 8: main CPU command byte.
- `cmd_wr` in 1: main CPU write enable. Level signal that may last many cycles; its rising edge is one write.
- `snd_rd` in 1: sound CPU read strobe for the latch. Level signal; its falling edge consumes the entry.
- `snd_irq_ack` in 1: sound CPU interrupt-acknowledge. Level signal; its rising edge is one acknowledge.
- `snd_data` out 8: byte presented to the sound CPU.
- `snd_irq_n` out 1: active-low interrupt to the sound CPU.
- `cmd_pending` out 1: at least one unconsumed entry.
- `overrun` out 1: sticky; set when a write finds the mailbox full.
- `fifo_level` out 4: number of stored entries (0..FIFO_DEPTH; 0/1 without FIFO).

## Operation
- Edge detect: `cmd_wr`, `snd_rd` and `snd_irq_ack` each have a one-stage previous-value register. Push = `cmd_wr & ~cmd_wr_q`. Pop = `~snd_rd & snd_rd_q`. Ack = `snd_irq_ack & ~ack_q`.
- Scheduler FSM:
  - IDLE → ASSERT when `cmd_pending` and not `pause`. The timeout counter loads 0.
  - ASSERT (`snd_irq_n`=0) → WAIT_READ on ack. → IDLE when the counter reaches `IRQ_TIMEOUT-1`; the entry stays pending, so IDLE re-asserts on the next cycle.
  - WAIT_READ (`snd_irq_n`=1) → IDLE on pop.
  - A pop in ASSERT also → IDLE, because polling drivers read without acknowledge.
- Pop is honoured in any state when non-empty. Pop when empty has no effect.
- `pause` blocks only IDLE→ASSERT and freezes the timeout counter. ASSERT and WAIT_READ still accept ack and pop.
- Simultaneous push+pop:
  - Level unchanged, and `overrun` is not set.
  - Single latch: the new byte is stored.
  - FIFO: the head pops and the tail is written.
- `overrun` clears only on reset.

## Timing
- Reset values: `snd_data`=0x00, `snd_irq_n`=1, `cmd_pending`=0, `overrun`=0, `fifo_level`=0, FSM=IDLE, edge registers=0.
- Push latency: the byte is captured at the first edge N that samples `cmd_wr`=1 with `cmd_wr_q`=0. `cmd_pending` and `fifo_level` update after edge N. `snd_irq_n` falls after edge N+1.
- Ack sampled at edge M: `snd_irq_n` rises after edge M.
- Pop sampled at edge P: level decrements after P. `snd_data` shows the next head after P.
- When empty, `snd_data` holds the last stored byte.
- Reset asserted mid-transfer: all state clears immediately and the entry is lost. `snd_irq_n` goes to 1 asynchronously.

## Configuration
- `SND_CMD_FIFO_EN` defined: a FIFO of `FIFO_DEPTH` entries. A push while full is dropped and sets `overrun`. `snd_data` is the head entry.
- `SND_CMD_FIFO_EN` undefined: a single 8-bit latch with a full flag, matching the original board. A push while full overwrites the latch and sets `overrun`. `fifo_level` is 0 or 1. `FIFO_DEPTH` is ignored.

## Structure
- Package `snd_cmd_pkg` holds:
  - the state enum `snd_mbox_state_t` {IDLE, ASSERT, WAIT_READ};
  - the constants `SND_IRQ_TIMEOUT_DEF`=4096 and `SND_FIFO_DEPTH_DEF`=4.
- Sub-module `snd_cmd_fifo` is compiled only under `SND_CMD_FIFO_EN`. It provides synchronous push/pop, an async reset, and data, level, full and empty outputs. The FSM and edge detectors stay in the top module.

## Test plan
- Basic transfer: reset, `cmd_wr` pulse 10 cycles with 0x5A → `cmd_pending`=1 one cycle after the edge. `snd_irq_n`=0 the cycle after that. Ack → `snd_irq_n`=1. `snd_rd` pulse → `cmd_pending`=0 and `snd_data`=0x5A.
- Timeout: with `IRQ_TIMEOUT`=16, push 0x11 and never ack → `snd_irq_n` low for exactly 16 cycles, high 1 cycle, then low again. `cmd_pending` stays 1.
- Overrun: push 0x01 then 0x02 without pop → single latch gives `snd_data`=0x02 and `overrun`=1. FIFO gives 0x01 then 0x02, with `overrun` set only on push FIFO_DEPTH+1.
- Simultaneous: level 1, then a push edge and a pop edge on the same cycle → level stays 1, `overrun`=0, and the new byte reaches the head.
- Pause: hold `pause`=1 and push 0x33 → `snd_irq_n` stays 1 and `cmd_pending`=1. Release `pause` → `snd_irq_n`=0 the next cycle.
- Reset mid-operation: assert `reset` in ASSERT with level 2 → `snd_irq_n`=1 and level 0 with no clock edge. After release, no interrupt until a new push.
